// File: rtl/hub_mem_arbiter_if.sv
// rtl/hub_mem_arbiter_if.sv - per-cog hub request/response bundle between the cogs and the hub memory arbiter
interface hub_mem_arbiter_if #(
    parameter int NCOG = 8,
    parameter int AW   = 14
);
    logic [NCOG-1:0]      req;
    logic [NCOG-1:0]      we;
    logic [4*NCOG-1:0]    wb;
    logic [AW*NCOG-1:0]   addr;
    logic [32*NCOG-1:0]   wdata;
    logic [NCOG-1:0]      ack;
    logic [NCOG-1:0]      rvalid;
    logic [31:0]          rdata;

    modport master (
        output req, we, wb, addr, wdata,
        input  ack, rvalid, rdata
    );

    modport slave (
        input  req, we, wb, addr, wdata,
        output ack, rvalid, rdata
    );
endinterface

// File: rtl/hub_mem_arbiter.sv
// rtl/hub_mem_arbiter.sv - time-slot arbiter sharing the single-port hub RAM among NCOG cogs
// Optional work-conserving mode (skip idle slot owner) enabled by defining HUB_ARB_SKIP_EN.
module hub_mem_arbiter #(
    parameter int NCOG = 8,
    parameter int SW   = 3,
    parameter int AW   = 14
) (
    input  logic                 clk_cog,
    input  logic                 nres,
    hub_mem_arbiter_if.slave     cog,
    output logic [SW-1:0]        slot,
    output logic                 mem_ena_bus,
    output logic                 mem_w,
    output logic [3:0]           mem_wb,
    output logic [AW-1:0]        mem_a,
    output logic [31:0]          mem_d,
    input  logic [31:0]          mem_q
);

    logic            gnt_valid;
    logic [SW-1:0]   gnt_idx;
    logic            rd_pend;
    logic [SW-1:0]   rd_owner;

`ifdef HUB_ARB_SKIP_EN
    logic [SW-1:0]   cand;

    // Search starts at the slot owner so it keeps priority; the SW-bit add wraps modulo NCOG.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = slot;
        cand      = slot;
        for (int k = 0; k < NCOG; k++) begin
            cand = slot + SW'(k);
            if (!gnt_valid && cog.req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
        gnt_valid = gnt_valid & nres;
    end
`else
    always_comb begin
        gnt_idx   = slot;
        gnt_valid = cog.req[slot] & nres;
    end
`endif

    // RAM port follows the granted cog; address/data stay on the slot owner when idle.
    always_comb begin
        cog.ack     = '0;
        mem_ena_bus = gnt_valid;
        mem_w       = 1'b0;
        mem_wb      = 4'b0000;
        mem_a       = cog.addr[AW*gnt_idx +: AW];
        mem_d       = cog.wdata[32*gnt_idx +: 32];
        if (gnt_valid) begin
            cog.ack[gnt_idx] = 1'b1;
            mem_w            = cog.we[gnt_idx];
            mem_wb           = cog.wb[4*gnt_idx +: 4];
        end
    end

    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            slot     <= '0;
            rd_pend  <= 1'b0;
            rd_owner <= '0;
        end else begin
            slot     <= slot + SW'(1);
            rd_pend  <= gnt_valid & ~cog.we[gnt_idx];
            rd_owner <= gnt_idx;
        end
    end

    always_comb begin
        cog.rvalid = '0;
        if (rd_pend)
            cog.rvalid[rd_owner] = 1'b1;
    end

    assign cog.rdata = mem_q;

endmodule

// File: tb/tb_hub_mem_arbiter.sv
// tb/tb_hub_mem_arbiter.sv - scoreboard bench for hub_mem_arbiter with a byte-lane RAM model
module tb_hub_mem_arbiter;
    localparam int NCOG = 8;
    localparam int SW   = 3;
    localparam int AW   = 14;

    logic              clk_cog = 1'b0;
    logic              nres    = 1'b0;
    logic [SW-1:0]     slot;
    logic              mem_ena_bus, mem_w;
    logic [3:0]        mem_wb;
    logic [AW-1:0]     mem_a;
    logic [31:0]       mem_d;
    logic [31:0]       mem_q = 32'h0;

    hub_mem_arbiter_if #(.NCOG(NCOG), .AW(AW)) bus ();

    hub_mem_arbiter #(.NCOG(NCOG), .SW(SW), .AW(AW)) dut (
        .clk_cog     (clk_cog),
        .nres        (nres),
        .cog         (bus),
        .slot        (slot),
        .mem_ena_bus (mem_ena_bus),
        .mem_w       (mem_w),
        .mem_wb      (mem_wb),
        .mem_a       (mem_a),
        .mem_d       (mem_d),
        .mem_q       (mem_q)
    );

    always #5 clk_cog = ~clk_cog;

    logic [31:0] ram [0:(1<<AW)-1];
    initial for (int i = 0; i < (1<<AW); i++) ram[i] = 32'hA500_0000 | i;

    always @(posedge clk_cog) begin : ram_model
        logic [31:0] nw;
        if (mem_ena_bus) begin
            if (mem_w) begin
                nw = ram[mem_a];
                for (int b = 0; b < 4; b++)
                    if (mem_wb[b]) nw[8*b +: 8] = mem_d[8*b +: 8];
                ram[mem_a] <= nw;
            end else begin
                mem_q <= ram[mem_a];
            end
        end
    end

    int cyc = 0;
    always @(posedge clk_cog) cyc <= cyc + 1;

    typedef struct {
        int          cog;
        bit          w;
        logic [3:0]  b;
        logic [13:0] a;
        logic [31:0] d;
        logic [31:0] q;
        bit          rd;
        int          slot_e;
        int          issue;
        int          lat;
    } exp_t;

    exp_t aq[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every grant pops an expectation; rvalid must follow one cycle later.
    logic [NCOG-1:0] exp_rv = '0;
    logic [31:0]     exp_q  = '0;
    always @(negedge clk_cog) begin : monitor
        exp_t e;
        if (exp_rv != 0 || bus.rvalid !== '0) begin
            checks++;
            if (bus.rvalid !== exp_rv || (exp_rv != 0 && bus.rdata !== exp_q)) begin
                failures++;
                $display("FAIL rvalid/rdata: got rvalid=%h rdata=%h expected rvalid=%h rdata=%h",
                         bus.rvalid, bus.rdata, exp_rv, exp_q);
            end
        end
        exp_rv = '0;
        if (bus.ack !== '0) begin
            checks++;
            if (aq.size() == 0) begin
                failures++;
                $display("FAIL ack_unexpected: got ack=%h expected none", bus.ack);
            end else begin
                e = aq.pop_front();
                if (bus.ack !== (NCOG'(1) << e.cog) || int'(slot) != e.slot_e || mem_ena_bus !== 1'b1 ||
                    mem_w !== e.w || mem_wb !== e.b || mem_a !== e.a ||
                    (e.w && mem_d !== e.d) || (cyc - e.issue) != e.lat) begin
                    failures++;
                    $display("FAIL grant cog%0d: got ack=%h slot=%0d ena=%b w=%b wb=%h a=%h d=%h lat=%0d expected ack=%h slot=%0d ena=1 w=%b wb=%h a=%h d=%h lat=%0d",
                             e.cog, bus.ack, slot, mem_ena_bus, mem_w, mem_wb, mem_a, mem_d, cyc - e.issue,
                             NCOG'(1) << e.cog, e.slot_e, e.w, e.b, e.a, e.d, e.lat);
                end
                if (e.rd) begin
                    exp_rv = NCOG'(1) << e.cog;
                    exp_q  = e.q;
                end
            end
        end
    end

    task automatic align(input int s);
        int n = 0;
        do begin
            @(posedge clk_cog); #1;
            n++;
        end while (int'(slot) != s && n < 2*NCOG);
    endtask

    task automatic acc(input int c, input bit w, input logic [3:0] b, input logic [13:0] a,
                       input logic [31:0] d, input logic [31:0] q, input int se, input int lat, input bit rd);
        exp_t e;
        e.cog = c; e.w = w; e.b = b; e.a = a; e.d = d; e.q = q;
        e.rd = rd; e.slot_e = se; e.issue = cyc; e.lat = lat;
        aq.push_back(e);
        bus.we[c]            = w;
        bus.wb[4*c +: 4]     = b;
        bus.addr[AW*c +: AW] = a;
        bus.wdata[32*c +: 32] = d;
        bus.req[c]           = 1'b1;
    endtask

    task automatic wait_acks(input logic [NCOG-1:0] mask);
        logic [NCOG-1:0] pending = mask;
        logic [NCOG-1:0] got;
        int n = 0;
        while (pending != 0 && n < 40) begin
            @(negedge clk_cog);
            got = bus.ack & pending;
            @(posedge clk_cog); #1;
            bus.req = bus.req & ~got;
            pending = pending & ~got;
            n++;
        end
        checks++;
        if (pending != 0) begin
            failures++;
            bus.req = bus.req & ~pending;
            $display("FAIL ack_timeout: got pending=%h expected 00", pending);
        end
    endtask

    task automatic single(input int c, input bit w, input logic [3:0] b, input logic [13:0] a,
                          input logic [31:0] d, input logic [31:0] q);
        align(c);
        acc(c, w, b, a, d, q, c, 0, !w);
        wait_acks(NCOG'(1) << c);
    endtask

    initial begin
        bus.req = '1; bus.we = '0; bus.wb = '0; bus.addr = '0; bus.wdata = '0;

        // Reset state with every cog requesting
        repeat (3) @(posedge clk_cog);
        @(negedge clk_cog);
        chk("reset_ack", 32'(bus.ack), 0);
        chk("reset_rvalid", 32'(bus.rvalid), 0);
        chk("reset_ena", 32'(mem_ena_bus), 0);
        chk("reset_slot", 32'(slot), 0);
        bus.req = '0;
        @(posedge clk_cog); #1;
        nres = 1'b1;
        for (int k = 0; k <= NCOG; k++) begin
            @(negedge clk_cog);
            chk($sformatf("slot_seq%0d", k), 32'(slot), k % NCOG);
        end

        // Write then read, cog 3
        single(3, 1'b1, 4'b1111, 14'h0123, 32'hDEADBEEF, 32'h0);
        single(3, 1'b0, 4'b0000, 14'h0123, 32'h0, 32'hDEADBEEF);

        // Byte lanes
        single(1, 1'b1, 4'b1111, 14'h0200, 32'hAAAAAAAA, 32'h0);
        single(1, 1'b1, 4'b0101, 14'h0200, 32'h11223344, 32'h0);
        single(1, 1'b0, 4'b0000, 14'h0200, 32'h0, 32'hAA22AA44);

        // Write with no byte enables leaves the word intact
        single(6, 1'b1, 4'b0000, 14'h0300, 32'h12345678, 32'h0);
        single(6, 1'b0, 4'b0000, 14'h0300, 32'h0, 32'hA5000300);

        // Write at G, read same address at G+1 sees new data
        align(3);
        acc(3, 1'b1, 4'b1111, 14'h0400, 32'h0BADF00D, 32'h0, 3, 0, 1'b0);
        acc(4, 1'b0, 4'b0000, 14'h0400, 32'h0, 32'h0BADF00D, 4, 1, 1'b1);
        wait_acks(8'h18);

        // Read at G, write same address at G+1 returns old data
        align(4);
        acc(4, 1'b0, 4'b0000, 14'h0500, 32'h0, 32'hA5000500, 4, 0, 1'b1);
        acc(5, 1'b1, 4'b1111, 14'h0500, 32'h5555AAAA, 32'h0, 5, 1, 1'b0);
        wait_acks(8'h30);
        single(7, 1'b0, 4'b0000, 14'h0500, 32'h0, 32'h5555AAAA);

        // All cogs read continuously for two rounds
        align(0);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < NCOG; c++) begin
                exp_t e;
                e.cog = c; e.w = 1'b0; e.b = 4'b0000; e.a = 14'(14'h0040 + c); e.d = 32'h0;
                e.q = 32'hA5000040 + c; e.rd = 1'b1; e.slot_e = c; e.issue = cyc; e.lat = 8*r + c;
                aq.push_back(e);
            end
        for (int c = 0; c < NCOG; c++) begin
            bus.we[c] = 1'b0; bus.wb[4*c +: 4] = 4'b0000;
            bus.addr[AW*c +: AW] = 14'(14'h0040 + c);
        end
        bus.req = '1;
        repeat (2*NCOG) @(posedge clk_cog);
        #1 bus.req = '0;
        repeat (2) @(posedge clk_cog);
        chk("stream_drained", 32'(aq.size()), 0);

        // Cog 5 alone, request raised while slot=6
        align(6);
`ifdef HUB_ARB_SKIP_EN
        acc(5, 1'b0, 4'b0000, 14'h0045, 32'h0, 32'hA5000045, 6, 0, 1'b1);
`else
        acc(5, 1'b0, 4'b0000, 14'h0045, 32'h0, 32'hA5000045, 5, 7, 1'b1);
`endif
        wait_acks(8'h20);

        // Reset pulse right after a read grant drops the pending rvalid
        align(2);
        acc(2, 1'b0, 4'b0000, 14'h0042, 32'h0, 32'h0, 2, 0, 1'b0);
        @(negedge clk_cog);
        #2;
        nres = 1'b0;
        bus.req = '0;
        @(posedge clk_cog); #1;
        nres = 1'b1;
        @(negedge clk_cog);
        chk("abort_rvalid", 32'(bus.rvalid), 0);
        chk("abort_slot", 32'(slot), 0);
        @(negedge clk_cog);
        chk("abort_rvalid2", 32'(bus.rvalid), 0);
        chk("abort_slot2", 32'(slot), 1);

        repeat (3) @(posedge clk_cog);
        chk("queue_empty", 32'(aq.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
